// File: rtl/rs_hs_pkg.sv
// rtl/rs_hs_pkg.sv - shared sizing helpers and memory-style codes for the relay-station handshake pipeline
package rs_hs_pkg;

    localparam int MEM_AUTO = 0;
    localparam int MEM_LUT  = 1;
    localparam int MEM_BRAM = 2;

    // Every register in the forward or return path adds one word that can still be in flight.
    function automatic int rs_hs_grace(input int body_level, input int ready_in_head,
                                       input int valid_in_head, input int extra);
        return 2 * body_level + ready_in_head + valid_in_head + extra;
    endfunction

    function automatic int rs_hs_real_depth(input int depth, input int grace);
        return grace + depth + 4;
    endfunction

endpackage

// File: rtl/rs_hs_tail_ram.sv
// rtl/rs_hs_tail_ram.sv - simple dual-port RAM, one write port and one registered read port
module rs_hs_tail_ram
    import rs_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 41,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MEM_STYLE  = MEM_AUTO
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    generate
        if (MEM_STYLE == MEM_LUT) begin : g_lut
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en) r_mem[wr_addr] <= wr_data;
                if (rd_en) rd_data <= r_mem[rd_addr];
            end
        end else if (MEM_STYLE == MEM_BRAM) begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en) r_mem[wr_addr] <= wr_data;
                if (rd_en) rd_data <= r_mem[rd_addr];
            end
        end else begin : g_auto
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en) r_mem[wr_addr] <= wr_data;
                if (rd_en) rd_data <= r_mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// rtl/rs_hs_pipeline_tail_fifo.sv - receiving tail of the handshake pipeline with grace-word absorption FIFO
module rs_hs_pipeline_tail_fifo
    import rs_hs_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 24,
    parameter int GRACE_PERIOD = rs_hs_grace(6, 1, 0, 0),
    parameter int REAL_DEPTH   = rs_hs_real_depth(DEPTH, GRACE_PERIOD),
    parameter int ADDR_WIDTH   = $clog2(REAL_DEPTH),
    parameter int CNT_WIDTH    = $clog2(REAL_DEPTH + 1),
    parameter int MEM_STYLE    = MEM_AUTO
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow
);

    localparam logic [CNT_WIDTH-1:0]  LP_FULL     = CNT_WIDTH'(REAL_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  LP_READY_TH = CNT_WIDTH'(REAL_DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST     = ADDR_WIDTH'(REAL_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_m_valid;
    logic                  r_s_ready;
    logic                  r_overflow;

    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic [CNT_WIDTH-1:0]  w_avail;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;

    // Writes are not gated by s_ready: grace words already in the body must still land.
    assign w_rd_fire = r_m_valid & m_ready;
    assign w_wr_fire = s_valid & ((r_count != LP_FULL) | w_rd_fire);

    always_comb begin
        w_count_next  = r_count + CNT_WIDTH'(w_wr_fire) - CNT_WIDTH'(w_rd_fire);
        // Words already resident in RAM after this cycle's read; this cycle's write is not yet readable.
        w_avail       = r_count - CNT_WIDTH'(w_rd_fire);
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_wr_fire) w_wr_ptr_next = (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
        if (w_rd_fire) w_rd_ptr_next = (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_m_valid  <= 1'b0;
            r_s_ready  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_m_valid  <= (w_avail != '0);
            r_s_ready  <= (w_count_next < LP_READY_TH);
            r_overflow <= r_overflow | (s_valid & ~w_wr_fire);
        end
    end

    // The RAM read register doubles as the FWFT output register, addressed by the next head.
    rs_hs_tail_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (REAL_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_STYLE  (MEM_STYLE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_fire & reset),
        .wr_addr (r_wr_ptr),
        .wr_data (s_data),
        .rd_en   (reset & (w_avail != '0)),
        .rd_addr (w_rd_ptr_next),
        .rd_data (m_data)
    );

    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
